// File: rtl/l1_read_arbiter_if.sv
// Bus bundle for the L1 read arbiter: the icache/dcache refill request and
// return ports plus the shared AXI4 read-address and read-data channels.
// The master modport is the arbiter's view: it drives AR, R-ready and
// the per-cache returns. The slave modport is the view of the environment
// (the caches plus the AXI slave).
interface l1_read_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
);
    // icache refill path
    logic                  icache_rd_req;
    logic [ADDR_WIDTH-1:0] icache_rd_addr;
    logic [LEN_WIDTH-1:0]  icache_rd_len;
    logic                  icache_rd_ack;
    logic                  icache_rvalid;
    logic                  icache_rlast;

    // dcache refill path
    logic                  dcache_rd_req;
    logic [ADDR_WIDTH-1:0] dcache_rd_addr;
    logic [LEN_WIDTH-1:0]  dcache_rd_len;
    logic                  dcache_rd_ack;
    logic                  dcache_rvalid;
    logic                  dcache_rlast;

    // shared return data
    logic [DATA_WIDTH-1:0] ret_rdata;

    // AXI4 AR channel
    logic                  arvalid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [LEN_WIDTH-1:0]  arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arready;

    // AXI4 R channel
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rlast;
    logic                  rready;

    // sticky length-mismatch flag
    logic                  len_err;

    modport master (
        input  icache_rd_req, icache_rd_addr, icache_rd_len,
        output icache_rd_ack, icache_rvalid, icache_rlast,
        input  dcache_rd_req, dcache_rd_addr, dcache_rd_len,
        output dcache_rd_ack, dcache_rvalid, dcache_rlast,
        output ret_rdata,
        output arvalid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rlast,
        output rready,
        output len_err
    );

    modport slave (
        output icache_rd_req, icache_rd_addr, icache_rd_len,
        input  icache_rd_ack, icache_rvalid, icache_rlast,
        output dcache_rd_req, dcache_rd_addr, dcache_rd_len,
        input  dcache_rd_ack, dcache_rvalid, dcache_rlast,
        input  ret_rdata,
        input  arvalid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rlast,
        input  rready,
        input  len_err
    );
endinterface

// File: rtl/l1_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel between the icache and
// dcache refill paths. One burst in flight at a time: a request is granted
// in IDLE, its AR is held in ADDR until arready, then R beats are steered
// to the owner with zero latency in DATA. Beat count is checked against
// arlen and any mismatch raises a sticky len_err.
module l1_read_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    l1_read_arbiter_if.master     bus
);

    localparam int CNT_WIDTH = LEN_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // registered state
    state_t                 state_r;
    logic                   owner_r;
    logic                   last_grant_r;
    logic                   arvalid_r;
    logic [ADDR_WIDTH-1:0]  araddr_r;
    logic [LEN_WIDTH-1:0]   arlen_r;
    logic                   icache_ack_r;
    logic                   dcache_ack_r;
    logic [CNT_WIDTH-1:0]   beat_cnt_r;
    logic                   len_err_r;

    // next-state values
    state_t                 state_s;
    logic                   grant_s;
    logic                   owner_s;
    logic                   last_grant_s;
    logic                   arvalid_s;
    logic [ADDR_WIDTH-1:0]  araddr_s;
    logic [LEN_WIDTH-1:0]   arlen_s;
    logic                   icache_ack_s;
    logic                   dcache_ack_s;
    logic [CNT_WIDTH-1:0]   beat_cnt_s;
    logic                   len_err_s;
    logic                   cnt_at_len_s;

    // combinational return path
    logic                   rready_s;
    logic                   icache_rvalid_s;
    logic                   icache_rlast_s;
    logic                   dcache_rvalid_s;
    logic                   dcache_rlast_s;
    logic [DATA_WIDTH-1:0]  ret_rdata_s;

    // Next-state logic: arbitration, AR handshake and beat accounting
    always_comb begin
        state_s      = state_r;
        grant_s      = owner_r;
        owner_s      = owner_r;
        last_grant_s = last_grant_r;
        arvalid_s    = arvalid_r;
        araddr_s     = araddr_r;
        arlen_s      = arlen_r;
        icache_ack_s = 1'b0;
        dcache_ack_s = 1'b0;
        beat_cnt_s   = beat_cnt_r;
        len_err_s    = len_err_r;
        cnt_at_len_s = (beat_cnt_r == {1'b0, arlen_r});

        case (state_r)
            ST_IDLE: begin
                // Tie goes to whoever was not served last; a lone requester wins outright.
                if (bus.icache_rd_req && bus.dcache_rd_req) begin
                    grant_s = (last_grant_r == OWNER_D) ? OWNER_I : OWNER_D;
                end else if (bus.icache_rd_req) begin
                    grant_s = OWNER_I;
                end else begin
                    grant_s = OWNER_D;
                end

                if (bus.icache_rd_req || bus.dcache_rd_req) begin
                    owner_s      = grant_s;
                    last_grant_s = grant_s;
                    arvalid_s    = 1'b1;
                    state_s      = ST_ADDR;
                    if (grant_s == OWNER_I) begin
                        araddr_s = bus.icache_rd_addr;
                        arlen_s  = bus.icache_rd_len;
                    end else begin
                        araddr_s = bus.dcache_rd_addr;
                        arlen_s  = bus.dcache_rd_len;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_ADDR: begin
                // araddr/arlen stay frozen while arvalid waits for arready.
                if (bus.arready) begin
                    arvalid_s  = 1'b0;
                    beat_cnt_s = '0;
                    state_s    = ST_DATA;
                    if (owner_r == OWNER_I) begin
                        icache_ack_s = 1'b1;
                    end else begin
                        dcache_ack_s = 1'b1;
                    end
                end else begin
                    state_s = ST_ADDR;
                end
            end

            ST_DATA: begin
                // rready is constant high here, so rvalid alone means a beat is taken.
                if (bus.rvalid) begin
                    beat_cnt_s = beat_cnt_r + CNT_WIDTH'(1);
                    if (bus.rlast) begin
                        if (!cnt_at_len_s) begin
                            len_err_s = 1'b1;
                        end else begin
                            len_err_s = len_err_r;
                        end
                        state_s = ST_IDLE;
                    end else if (cnt_at_len_s) begin
                        // Expected final beat arrived without rlast: flag it, keep draining.
                        len_err_s = 1'b1;
                    end else begin
                        len_err_s = len_err_r;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end

            default: begin
                state_s   = ST_IDLE;
                arvalid_s = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset; icache wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWNER_I;
            last_grant_r <= OWNER_D;
            arvalid_r    <= 1'b0;
            araddr_r     <= '0;
            arlen_r      <= '0;
            icache_ack_r <= 1'b0;
            dcache_ack_r <= 1'b0;
            beat_cnt_r   <= '0;
            len_err_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            last_grant_r <= last_grant_s;
            arvalid_r    <= arvalid_s;
            araddr_r     <= araddr_s;
            arlen_r      <= arlen_s;
            icache_ack_r <= icache_ack_s;
            dcache_ack_r <= dcache_ack_s;
            beat_cnt_r   <= beat_cnt_s;
            len_err_r    <= len_err_s;
        end
    end

    // Zero-latency R steering: only the owner sees beats, and only in DATA
    always_comb begin
        rready_s        = 1'b0;
        icache_rvalid_s = 1'b0;
        icache_rlast_s  = 1'b0;
        dcache_rvalid_s = 1'b0;
        dcache_rlast_s  = 1'b0;
        ret_rdata_s     = '0;
        if (state_r == ST_DATA) begin
            rready_s    = 1'b1;
            ret_rdata_s = bus.rdata;
            if (owner_r == OWNER_I) begin
                icache_rvalid_s = bus.rvalid;
                icache_rlast_s  = bus.rvalid && bus.rlast;
            end else begin
                dcache_rvalid_s = bus.rvalid;
                dcache_rlast_s  = bus.rvalid && bus.rlast;
            end
        end else begin
            rready_s    = 1'b0;
            ret_rdata_s = '0;
        end
    end

    assign bus.arvalid       = arvalid_r;
    assign bus.araddr        = araddr_r;
    assign bus.arlen         = arlen_r;
    assign bus.arsize        = 3'b010;
    assign bus.arburst       = 2'b01;
    assign bus.icache_rd_ack = icache_ack_r;
    assign bus.dcache_rd_ack = dcache_ack_r;
    assign bus.len_err       = len_err_r;
    assign bus.rready        = rready_s;
    assign bus.icache_rvalid = icache_rvalid_s;
    assign bus.icache_rlast  = icache_rlast_s;
    assign bus.dcache_rvalid = dcache_rvalid_s;
    assign bus.dcache_rlast  = dcache_rlast_s;
    assign bus.ret_rdata     = ret_rdata_s;

endmodule

// File: tb/tb_l1_read_arbiter.sv
// Directed bench for l1_read_arbiter: a per-cycle vector table for the main
// burst scenarios plus hand-written sequences for length overrun and
// reset in the middle of a burst.
module tb_l1_read_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    l1_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8)) bus ();

    l1_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flag bits: {arvalid, i_ack, d_ack, i_rvalid, i_rlast, d_rvalid, d_rlast, rready, len_err}
    localparam logic [8:0] F_ARV  = 9'h100;
    localparam logic [8:0] F_IACK = 9'h080;
    localparam logic [8:0] F_DACK = 9'h040;
    localparam logic [8:0] F_IRV  = 9'h020;
    localparam logic [8:0] F_IRL  = 9'h010;
    localparam logic [8:0] F_DRV  = 9'h008;
    localparam logic [8:0] F_DRL  = 9'h004;
    localparam logic [8:0] F_RDY  = 9'h002;
    localparam logic [8:0] F_ERR  = 9'h001;

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [31:0] iaddr;
        logic [7:0]  ilen;
        logic        dreq;
        logic [31:0] daddr;
        logic [7:0]  dlen;
        logic        arready;
        logic        rvalid;
        logic        rlast;
        logic [31:0] rdata;
        logic [8:0]  exp_flags;
        logic [31:0] exp_araddr;
        logic [7:0]  exp_arlen;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic ir, input logic [31:0] ia, input logic [7:0] il,
                                input logic dr, input logic [31:0] da, input logic [7:0] dl,
                                input logic ar, input logic rv, input logic rl, input logic [31:0] rd,
                                input logic [8:0] ef, input logic [31:0] ea, input logic [7:0] el,
                                input logic [31:0] ed);
        vec_t v;
        v.rst = r; v.ireq = ir; v.iaddr = ia; v.ilen = il;
        v.dreq = dr; v.daddr = da; v.dlen = dl;
        v.arready = ar; v.rvalid = rv; v.rlast = rl; v.rdata = rd;
        v.exp_flags = ef; v.exp_araddr = ea; v.exp_arlen = el; v.exp_rdata = ed;
        return v;
    endfunction

    function automatic logic [8:0] flags();
        return {bus.arvalid, bus.icache_rd_ack, bus.dcache_rd_ack, bus.icache_rvalid,
                bus.icache_rlast, bus.dcache_rvalid, bus.dcache_rlast, bus.rready, bus.len_err};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.icache_rd_req  = 1'b0;
        bus.icache_rd_addr = 32'h0;
        bus.icache_rd_len  = 8'd0;
        bus.dcache_rd_req  = 1'b0;
        bus.dcache_rd_addr = 32'h0;
        bus.dcache_rd_len  = 8'd0;
        bus.arready        = 1'b0;
        bus.rvalid         = 1'b0;
        bus.rdata          = 32'h0;
        bus.rlast          = 1'b0;
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        rst                = v.rst;
        bus.icache_rd_req  = v.ireq;
        bus.icache_rd_addr = v.iaddr;
        bus.icache_rd_len  = v.ilen;
        bus.dcache_rd_req  = v.dreq;
        bus.dcache_rd_addr = v.daddr;
        bus.dcache_rd_len  = v.dlen;
        bus.arready        = v.arready;
        bus.rvalid         = v.rvalid;
        bus.rlast          = v.rlast;
        bus.rdata          = v.rdata;
        #1;
        chk($sformatf("vec%0d flags", idx),  {55'd0, flags()},      {55'd0, v.exp_flags});
        chk($sformatf("vec%0d araddr", idx), {32'd0, bus.araddr},   {32'd0, v.exp_araddr});
        chk($sformatf("vec%0d arlen", idx),  {56'd0, bus.arlen},    {56'd0, v.exp_arlen});
        chk($sformatf("vec%0d rdata", idx),  {32'd0, bus.ret_rdata}, {32'd0, v.exp_rdata});
    endtask

    initial begin
        logic [31:0] ia;
        logic [7:0]  il;
        logic [31:0] da;
        logic [7:0]  dl;

        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive_idle();

        // A: single icache burst, 4 beats, arready already high
        ia = 32'h1C00_0040; il = 8'd3; da = 32'h0; dl = 8'd0;
        vecs.push_back(mk(1'b0, 1'b1, ia, il, 1'b0, da, dl, 1'b1, 1'b0, 1'b0, 32'h0,  9'h000, 32'h0, 8'd0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, ia, il, 1'b0, da, dl, 1'b1, 1'b0, 1'b0, 32'h0,  F_ARV, ia, il, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, ia, il, 1'b0, da, dl, 1'b0, 1'b1, 1'b0, 32'h11, F_IACK|F_RDY|F_IRV, ia, il, 32'h11));
        vecs.push_back(mk(1'b0, 1'b0, ia, il, 1'b0, da, dl, 1'b0, 1'b1, 1'b0, 32'h22, F_RDY|F_IRV, ia, il, 32'h22));
        vecs.push_back(mk(1'b0, 1'b0, ia, il, 1'b0, da, dl, 1'b0, 1'b1, 1'b0, 32'h33, F_RDY|F_IRV, ia, il, 32'h33));
        vecs.push_back(mk(1'b0, 1'b0, ia, il, 1'b0, da, dl, 1'b0, 1'b1, 1'b1, 32'h44, F_RDY|F_IRV|F_IRL, ia, il, 32'h44));
        vecs.push_back(mk(1'b0, 1'b0, ia, il, 1'b0, da, dl, 1'b0, 1'b1, 1'b1, 32'h55, 9'h000, ia, il, 32'h0));

        // B: reset, then both requesting continuously: grants I, D, I
        vecs.push_back(mk(1'b1, 1'b0, ia, il, 1'b0, da, dl, 1'b0, 1'b0, 1'b0, 32'h0, 9'h000, ia, il, 32'h0));
        ia = 32'h100; il = 8'd1; da = 32'h200; dl = 8'd1;
        vecs.push_back(mk(1'b0, 1'b1, ia, il, 1'b1, da, dl, 1'b1, 1'b0, 1'b0, 32'h0,  9'h000, 32'h0, 8'd0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, ia, il, 1'b1, da, dl, 1'b1, 1'b0, 1'b0, 32'h0,  F_ARV, ia, il, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, ia, il, 1'b1, da, dl, 1'b0, 1'b1, 1'b0, 32'hA0, F_IACK|F_RDY|F_IRV, ia, il, 32'hA0));
        vecs.push_back(mk(1'b0, 1'b1, ia, il, 1'b1, da, dl, 1'b0, 1'b1, 1'b1, 32'hA1, F_RDY|F_IRV|F_IRL, ia, il, 32'hA1));
        vecs.push_back(mk(1'b0, 1'b1, ia, il, 1'b1, da, dl, 1'b1, 1'b0, 1'b0, 32'h0,  9'h000, ia, il, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, ia, il, 1'b1, da, dl, 1'b1, 1'b0, 1'b0, 32'h0,  F_ARV, da, dl, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, ia, il, 1'b1, da, dl, 1'b0, 1'b1, 1'b0, 32'hB0, F_DACK|F_RDY|F_DRV, da, dl, 32'hB0));
        vecs.push_back(mk(1'b0, 1'b1, ia, il, 1'b1, da, dl, 1'b0, 1'b1, 1'b1, 32'hB1, F_RDY|F_DRV|F_DRL, da, dl, 32'hB1));
        vecs.push_back(mk(1'b0, 1'b1, ia, il, 1'b1, da, dl, 1'b1, 1'b0, 1'b0, 32'h0,  9'h000, da, dl, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, ia, il, 1'b1, da, dl, 1'b1, 1'b0, 1'b0, 32'h0,  F_ARV, ia, il, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, ia, il, 1'b0, da, dl, 1'b0, 1'b1, 1'b0, 32'hC0, F_IACK|F_RDY|F_IRV, ia, il, 32'hC0));
        vecs.push_back(mk(1'b0, 1'b0, ia, il, 1'b0, da, dl, 1'b0, 1'b1, 1'b1, 32'hC1, F_RDY|F_IRV|F_IRL, ia, il, 32'hC1));

        // C: dcache single beat with arready low for 5 cycles
        ia = 32'h0; il = 8'd0; da = 32'h300; dl = 8'd0;
        vecs.push_back(mk(1'b0, 1'b0, ia, il, 1'b1, da, dl, 1'b0, 1'b0, 1'b0, 32'h0, 9'h000, 32'h100, 8'd1, 32'h0));
        for (int k = 0; k < 5; k++) begin
            vecs.push_back(mk(1'b0, 1'b0, ia, il, 1'b1, da, dl, 1'b0, 1'b0, 1'b0, 32'h0, F_ARV, da, dl, 32'h0));
        end
        vecs.push_back(mk(1'b0, 1'b0, ia, il, 1'b1, da, dl, 1'b1, 1'b0, 1'b0, 32'h0,  F_ARV, da, dl, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, ia, il, 1'b0, da, dl, 1'b0, 1'b1, 1'b1, 32'hD0, F_DACK|F_RDY|F_DRV|F_DRL, da, dl, 32'hD0));
        vecs.push_back(mk(1'b0, 1'b0, ia, il, 1'b0, da, dl, 1'b0, 1'b0, 1'b0, 32'h0,  9'h000, da, dl, 32'h0));

        // D: icache len=3 with R gaps 1,0,0,1,1,0,1(last)
        ia = 32'h400; il = 8'd3; da = 32'h0; dl = 8'd0;
        vecs.push_back(mk(1'b0, 1'b1, ia, il, 1'b0, da, dl, 1'b1, 1'b0, 1'b0, 32'h0,  9'h000, 32'h300, 8'd0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, ia, il, 1'b0, da, dl, 1'b1, 1'b0, 1'b0, 32'h0,  F_ARV, ia, il, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, ia, il, 1'b0, da, dl, 1'b0, 1'b1, 1'b0, 32'hE0, F_IACK|F_RDY|F_IRV, ia, il, 32'hE0));
        vecs.push_back(mk(1'b0, 1'b0, ia, il, 1'b0, da, dl, 1'b0, 1'b0, 1'b0, 32'h0,  F_RDY, ia, il, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, ia, il, 1'b0, da, dl, 1'b0, 1'b0, 1'b0, 32'h0,  F_RDY, ia, il, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, ia, il, 1'b0, da, dl, 1'b0, 1'b1, 1'b0, 32'hE2, F_RDY|F_IRV, ia, il, 32'hE2));
        vecs.push_back(mk(1'b0, 1'b0, ia, il, 1'b0, da, dl, 1'b0, 1'b1, 1'b0, 32'hE3, F_RDY|F_IRV, ia, il, 32'hE3));
        vecs.push_back(mk(1'b0, 1'b0, ia, il, 1'b0, da, dl, 1'b0, 1'b0, 1'b0, 32'h0,  F_RDY, ia, il, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, ia, il, 1'b0, da, dl, 1'b0, 1'b1, 1'b1, 32'hE4, F_RDY|F_IRV|F_IRL, ia, il, 32'hE4));
        vecs.push_back(mk(1'b0, 1'b0, ia, il, 1'b0, da, dl, 1'b0, 1'b0, 1'b0, 32'h0,  9'h000, ia, il, 32'h0));

        // E: dcache len=3 but rlast on beat 2 -> len_err, back to IDLE
        ia = 32'h0; il = 8'd0; da = 32'h500; dl = 8'd3;
        vecs.push_back(mk(1'b0, 1'b0, ia, il, 1'b1, da, dl, 1'b1, 1'b0, 1'b0, 32'h0,  9'h000, 32'h400, 8'd3, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, ia, il, 1'b1, da, dl, 1'b1, 1'b0, 1'b0, 32'h0,  F_ARV, da, dl, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, ia, il, 1'b0, da, dl, 1'b0, 1'b1, 1'b0, 32'hF0, F_DACK|F_RDY|F_DRV, da, dl, 32'hF0));
        vecs.push_back(mk(1'b0, 1'b0, ia, il, 1'b0, da, dl, 1'b0, 1'b1, 1'b1, 32'hF1, F_RDY|F_DRV|F_DRL, da, dl, 32'hF1));
        vecs.push_back(mk(1'b0, 1'b0, ia, il, 1'b0, da, dl, 1'b0, 1'b0, 1'b0, 32'h0,  F_ERR, da, dl, 32'h0));

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset flags",   {55'd0, flags()},       64'h0);
        chk("reset araddr",  {32'd0, bus.araddr},    64'h0);
        chk("reset arlen",   {56'd0, bus.arlen},     64'h0);
        chk("reset rdata",   {32'd0, bus.ret_rdata}, 64'h0);
        chk("arsize",        {61'd0, bus.arsize},    64'h2);
        chk("arburst",       {62'd0, bus.arburst},   64'h1);

        foreach (vecs[i]) begin
            apply(i, vecs[i]);
        end

        // F: len=1 but rlast only on beat 4
        @(negedge clk); rst = 1'b1; drive_idle();
        @(negedge clk); rst = 1'b0;
        bus.icache_rd_req = 1'b1; bus.icache_rd_addr = 32'h600; bus.icache_rd_len = 8'd1; bus.arready = 1'b1;
        @(negedge clk); #1;
        chk("ovr arvalid", {63'd0, bus.arvalid}, 64'h1);
        @(negedge clk);
        bus.icache_rd_req = 1'b0; bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h1; bus.rlast = 1'b0;
        #1;
        chk("ovr beat1 ack",    {63'd0, bus.icache_rd_ack}, 64'h1);
        chk("ovr beat1 len_err", {63'd0, bus.len_err},      64'h0);
        @(negedge clk); bus.rdata = 32'h2; #1;
        chk("ovr beat2 len_err", {63'd0, bus.len_err},       64'h0);
        chk("ovr beat2 rvalid",  {63'd0, bus.icache_rvalid}, 64'h1);
        @(negedge clk); bus.rdata = 32'h3; #1;
        chk("ovr beat3 len_err", {63'd0, bus.len_err},      64'h1);
        chk("ovr beat3 rlast",   {63'd0, bus.icache_rlast}, 64'h0);
        @(negedge clk); bus.rdata = 32'h4; bus.rlast = 1'b1; #1;
        chk("ovr beat4 rlast",  {63'd0, bus.icache_rlast},  64'h1);
        chk("ovr beat4 rvalid", {63'd0, bus.icache_rvalid}, 64'h1);
        @(negedge clk); bus.rvalid = 1'b0; bus.rlast = 1'b0; #1;
        chk("ovr idle rready",  {63'd0, bus.rready},  64'h0);
        chk("ovr idle len_err", {63'd0, bus.len_err}, 64'h1);

        // G: reset after beat 1 of a 4-beat dcache burst
        @(negedge clk); rst = 1'b1; drive_idle();
        @(negedge clk); rst = 1'b0;
        bus.dcache_rd_req = 1'b1; bus.dcache_rd_addr = 32'h700; bus.dcache_rd_len = 8'd3; bus.arready = 1'b1;
        #1;
        chk("rstmid len_err cleared", {63'd0, bus.len_err}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        bus.dcache_rd_req = 1'b0; bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h71;
        #1;
        chk("rstmid beat1", {63'd0, bus.dcache_rvalid}, 64'h1);
        @(negedge clk); rst = 1'b1; bus.rvalid = 1'b0;
        @(negedge clk); rst = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h72; #1;
        chk("rstmid flags",  {55'd0, flags()},       64'h0);
        chk("rstmid araddr", {32'd0, bus.araddr},    64'h0);
        chk("rstmid arlen",  {56'd0, bus.arlen},     64'h0);
        chk("rstmid rdata",  {32'd0, bus.ret_rdata}, 64'h0);
        @(negedge clk); bus.rdata = 32'h73; bus.rlast = 1'b1; #1;
        chk("rstmid late beat", {55'd0, flags()}, 64'h0);
        @(negedge clk); drive_idle(); #1;
        chk("rstmid after", {55'd0, flags()}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
